// File: rtl/countdown_game_core_pkg.sv
// Shared types and seven-segment glyphs for the countdown game core.
// Segment encoding is active-low, bit order gfedcba.
package countdown_pkg;

  typedef enum logic [1:0] {IDLE, RUN, WIN, LOSE} state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/countdown_game_core_if.sv
// Player/display bus of the countdown game core. The game core is the slave;
// the board (or bench) side is the master.
interface countdown_game_core_if #(
  parameter int SW_WIDTH = 8,
  parameter int NDIGITS  = 4
) ();

  logic                start;
  logic                stop;
  logic                multiply;
  logic [SW_WIDTH-1:0] sw;
  logic [7:0]          led;
  logic [6:0]          seg;
  logic [NDIGITS-1:0]  an;
  logic                dp;

  modport master (
    output start, stop, multiply, sw,
    input  led, seg, an, dp
  );

  modport slave (
    input  start, stop, multiply, sw,
    output led, seg, an, dp
  );

endinterface

// File: rtl/countdown_game_core_digit_scanner.sv
// Time-multiplexed seven-segment scanner: one digit per SCAN_DIV-cycle slot;
// an/seg/dp are registered and reload together only at slot boundaries.
module digit_scanner
  import countdown_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int SCAN_DIV = 65536
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NDIGITS-1:0][6:0] glyph_i,
  input  logic [NDIGITS-1:0]      dp_i,
  output logic [NDIGITS-1:0]      an_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NDIGITS);

  logic [DW-1:0]      div_q, div_d;
  logic [IW-1:0]      idx_q, idx_d, idx_nxt;
  logic [NDIGITS-1:0] an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               slot_end;

  always_comb begin
    slot_end = (div_q == '0);
    div_d    = slot_end ? DW'(SCAN_DIV - 1) : div_q - 1'b1;
    idx_nxt  = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
    idx_d    = idx_q;
    an_d     = an_q;
    seg_d    = seg_q;
    dp_d     = dp_q;
    if (slot_end) begin
      idx_d = idx_nxt;
      an_d  = ~(NDIGITS'(1) << idx_nxt);
      seg_d = glyph_i[idx_nxt];
      dp_d  = dp_i[idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= DW'(SCAN_DIV - 1);
      idx_q <= '0;
      an_q  <= ~NDIGITS'(1);
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: rtl/countdown_game_core.sv
// Countdown guessing game: popcount guess, one-second countdown FSM, display mux.
// Optional macro COUNTDOWN_SPLASH_EN shows "CL0." while idle.
//
// state | meaning
// IDLE  | waiting for start, count held at START_VALUE
// RUN   | counting down once per CLOCK cycles
// WIN   | stopped with count == guess, frozen until reset
// LOSE  | wrong guess or count reached 0, frozen until reset
module countdown_game_core
  import countdown_pkg::*;
#(
  parameter int CLOCK       = 50000000,
  parameter int SW_WIDTH    = 8,
  parameter int NDIGITS     = 4,
  parameter int START_VALUE = 10,
  parameter int SCAN_DIV    = 65536
) (
  input logic                  clk,
  input logic                  reset,
  countdown_game_core_if.slave bus
);

  localparam int PW = (CLOCK > 1) ? $clog2(CLOCK) : 1;

  state_e                  state_q, state_d;
  logic [6:0]              count_q, count_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [7:0]              led_q, led_d;
  logic [7:0]              pop;
  logic                    tick;
  logic [6:0]              ones, tens;
  logic [6:0]              tens_glyph;
  logic [NDIGITS-1:0][6:0] glyph;
  logic [NDIGITS-1:0]      dp_vec;

  always_comb begin
    pop = '0;
    for (int i = 0; i < SW_WIDTH; i++) pop = pop + 8'(bus.sw[i]);
    led_d = bus.multiply ? {pop[6:0], 1'b0} : pop;
  end

  // Stop takes priority over a coincident tick: judge on the undecremented count.
  always_comb begin
    tick    = (presc_q == PW'(CLOCK - 1));
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          count_d = 7'(START_VALUE);
          presc_d = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = ({1'b0, count_q} == led_q) ? WIN : LOSE;
        end else if (tick) begin
          presc_d = '0;
          count_d = count_q - 1'b1;
          if (count_q == 7'd1) state_d = LOSE;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 7'(START_VALUE);
      presc_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    ones       = count_q % 7'd10;
    tens       = count_q / 7'd10;
    tens_glyph = (tens == '0) ? SEG_BLANK : bcd_to_seg(tens[3:0]);
    glyph      = {NDIGITS{SEG_BLANK}};
    dp_vec     = '1;
    case (state_q)
      IDLE: begin
`ifdef COUNTDOWN_SPLASH_EN
        if (NDIGITS > 2) glyph[2] = SEG_C;
        glyph[1]  = SEG_L;
        glyph[0]  = SEG_0;
        dp_vec[0] = 1'b0;
`endif
      end
      RUN: begin
        glyph[0] = bcd_to_seg(ones[3:0]);
        glyph[1] = tens_glyph;
      end
      WIN: begin
        glyph[0] = SEG_U;
        glyph[1] = tens_glyph;
      end
      LOSE: begin
        glyph[0] = SEG_L;
        glyph[1] = tens_glyph;
      end
      default: ;
    endcase
  end

  digit_scanner #(
    .NDIGITS  (NDIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scanner (
    .clk     (clk),
    .reset   (reset),
    .glyph_i (glyph),
    .dp_i    (dp_vec),
    .an_o    (bus.an),
    .seg_o   (bus.seg),
    .dp_o    (bus.dp)
  );

  assign bus.led = led_q;

endmodule

// File: tb/tb_countdown_game_core.sv
// Directed bench for countdown_game_core with CLOCK=20, SCAN_DIV=2, NDIGITS=4.
module tb_countdown_game_core;
  import countdown_pkg::*;

  localparam int NDIG = 4;
  localparam int SDIV = 2;
`ifdef COUNTDOWN_SPLASH_EN
  localparam bit SPLASH = 1'b1;
`else
  localparam bit SPLASH = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [6:0] cap_seg [NDIG];
  logic       cap_dp  [NDIG];

  countdown_game_core_if #(.SW_WIDTH(8), .NDIGITS(NDIG)) bus ();

  countdown_game_core #(
    .CLOCK       (20),
    .SW_WIDTH    (8),
    .NDIGITS     (NDIG),
    .START_VALUE (10),
    .SCAN_DIV    (SDIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let any pending display update flush, then record one full scan round.
  task automatic capture();
    bit ok = 1'b1;
    for (int d = 0; d < NDIG; d++) begin
      cap_seg[d] = 7'h00;
      cap_dp[d]  = 1'bx;
    end
    repeat (NDIG * SDIV + 1) step();
    for (int i = 0; i < NDIG * SDIV; i++) begin
      step();
      if ($countones(~bus.an) != 1) ok = 1'b0;
      for (int d = 0; d < NDIG; d++) begin
        if (bus.an[d] == 1'b0) begin
          cap_seg[d] = bus.seg;
          cap_dp[d]  = bus.dp;
        end
      end
    end
    check("an_one_low", 32'(ok), 32'd1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.multiply = 1'b0;
    bus.sw       = 8'h00;
    repeat (3) step();
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_count", 32'(dut.count_q), 32'd10);
    check("rst_led",   32'(bus.led), 32'd0);
    check("rst_seg",   32'(bus.seg), 32'h7F);
    check("rst_an",    32'(bus.an),  32'b1110);
    check("rst_dp",    32'(bus.dp),  32'd1);
    reset = 1'b0;

    // Guess path: popcount(1011_0001)=4, doubled=8
    bus.sw = 8'b1011_0001;
    step();
    check("led_x1", 32'(bus.led), 32'd4);
    bus.multiply = 1'b1;
    step();
    check("led_x2", 32'(bus.led), 32'd8);
    bus.multiply = 1'b0;

    capture();
    check("idle_d0_seg", 32'(cap_seg[0]), SPLASH ? 32'h40 : 32'h7F);
    check("idle_d0_dp",  32'(cap_dp[0]),  SPLASH ? 32'd0  : 32'd1);
    check("idle_d2_seg", 32'(cap_seg[2]), SPLASH ? 32'h46 : 32'h7F);
    check("idle_d3_seg", 32'(cap_seg[3]), 32'h7F);

    // Countdown to 6, then stop with guess 6 -> WIN
    bus.sw = 8'b0011_1111;
    pulse_start();
    repeat (80) step();
    check("run_count6", 32'(dut.count_q), 32'd6);
    capture();
    check("run_d0_six",   32'(cap_seg[0]), 32'h02);
    check("run_d1_blank", 32'(cap_seg[1]), 32'h7F);
    check("run_d0_dp",    32'(cap_dp[0]),  32'd1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("win_state", 32'(dut.state_q), 32'(WIN));
    capture();
    check("win_d0_U", 32'(cap_seg[0]), 32'h41);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    repeat (3) step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (200) step();
    check("win_hold_state", 32'(dut.state_q), 32'(WIN));
    check("win_hold_count", 32'(dut.count_q), 32'd6);

    // No stop: LOSE exactly 200 cycles after start
    do_reset();
    check("rst2_state", 32'(dut.state_q), 32'(IDLE));
    pulse_start();
    repeat (199) step();
    check("c199_state", 32'(dut.state_q), 32'(RUN));
    check("c199_count", 32'(dut.count_q), 32'd1);
    step();
    check("c200_state", 32'(dut.state_q), 32'(LOSE));
    check("c200_count", 32'(dut.count_q), 32'd0);
    capture();
    check("lose_d0_L",     32'(cap_seg[0]), 32'h47);
    check("lose_d1_blank", 32'(cap_seg[1]), 32'h7F);

    // Stop coincident with tick at count 5, guess 5 -> WIN, no decrement
    do_reset();
    bus.sw = 8'b0001_1111;
    step();
    check("led5", 32'(bus.led), 32'd5);
    pulse_start();
    repeat (119) step();
    check("pre_tick_count", 32'(dut.count_q), 32'd5);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("tie_state", 32'(dut.state_q), 32'(WIN));
    check("tie_count", 32'(dut.count_q), 32'd5);

    // Wrong guess -> LOSE, count frozen
    do_reset();
    step();
    pulse_start();
    repeat (5) step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("miss_state", 32'(dut.state_q), 32'(LOSE));
    check("miss_count", 32'(dut.count_q), 32'd10);

    // Reset mid-RUN aborts the round
    do_reset();
    pulse_start();
    repeat (30) step();
    check("mid_state", 32'(dut.state_q), 32'(RUN));
    reset = 1'b1;
    step();
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    check("abort_count", 32'(dut.count_q), 32'd10);
    check("abort_an",    32'(bus.an),  32'b1110);
    check("abort_seg",   32'(bus.seg), 32'h7F);
    check("abort_dp",    32'(bus.dp),  32'd1);
    check("abort_led",   32'(bus.led), 32'd0);
    reset = 1'b0;
    capture();
    check("post_d0_seg", 32'(cap_seg[0]), SPLASH ? 32'h40 : 32'h7F);
    check("post_d0_dp",  32'(cap_dp[0]),  SPLASH ? 32'd0  : 32'd1);
    check("post_d1_seg", 32'(cap_seg[1]), SPLASH ? 32'h47 : 32'h7F);
    check("post_d1_dp",  32'(cap_dp[1]),  32'd1);
    check("post_d2_seg", 32'(cap_seg[2]), SPLASH ? 32'h46 : 32'h7F);
    check("post_d3_seg", 32'(cap_seg[3]), 32'h7F);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/countdown_game_core.md
COUNTDOWN_GAME_CORE -- requirements
Module: countdown_game_core

Interface
REQ-001 Parameter CLOCK, default 50000000: clk cycles per one-second countdown tick.
REQ-002 Parameter SW_WIDTH, default 8: number of switch inputs; legal range 1..49.
REQ-003 Parameter NDIGITS, default 4: number of seven-segment digits scanned; legal range 2..8.
REQ-004 Parameter START_VALUE, default 10: countdown start value; legal range 1..99.
REQ-005 Parameter SCAN_DIV, default 65536: clk cycles per digit scan slot.
REQ-006 Port clk, input, 1: the single clock; all logic updates on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port start, input, 1: level; in IDLE, begins a round.
REQ-009 Port stop, input, 1: level; in RUN, freezes the count and judges the guess.
REQ-010 Port multiply, input, 1: when high, the guess value is doubled.
REQ-011 Port sw, input, SW_WIDTH: player switches.
REQ-012 Port led, output, 8: current guess value, unsigned.
REQ-013 Port seg, output, 7: active-low segments, bit order gfedcba.
REQ-014 Port an, output, NDIGITS: active-low digit enables; an[0] is the rightmost digit.
REQ-015 Port dp, output, 1: active-low decimal point of the enabled digit.

Function
REQ-016 led SHALL equal popcount(sw), shifted left by one when multiply=1, registered; latency 1 cycle; no saturation is needed because 2*49 < 256.
REQ-017 The FSM SHALL have the states IDLE, RUN, WIN and LOSE.
REQ-018 IDLE->RUN SHALL occur on start=1; the count SHALL load START_VALUE and the tick prescaler SHALL clear.
REQ-019 In RUN the count SHALL decrement by 1 each time the prescaler reaches CLOCK-1, and the prescaler SHALL then wrap to 0.
REQ-020 In RUN with stop=1, the next state SHALL be WIN if count==led, else LOSE; the count SHALL freeze in either case.
REQ-021 In RUN, if a tick brings the count to 0 without stop, the next state SHALL be LOSE.
REQ-022 If stop=1 and a tick occur in the same cycle, stop SHALL win: the judgement SHALL use the pre-decrement count and no decrement SHALL occur.
REQ-023 The FSM SHALL leave WIN and LOSE only via reset; start and stop SHALL be ignored there.
REQ-024 The scan index SHALL advance 0..NDIGITS-1 and wrap every SCAN_DIV cycles; exactly one an bit SHALL be low per slot, in every state.
REQ-025 In RUN, digit 0 SHALL show count ones and digit 1 count tens; tens SHALL be blanked (seg=7'h7F) when zero; higher digits SHALL be blanked.
REQ-026 In WIN, digit 0 SHALL show 'U' (7'b1000001); in LOSE, digit 0 SHALL show 'L' (7'b1000111); digit 1 SHALL keep the frozen count; other digits SHALL be blanked.
REQ-027 dp SHALL be 1 (off) except where REQ-030 lights it.
REQ-028 The seg, an and dp outputs SHALL be registered and SHALL change only together, on a slot boundary.

Reset
REQ-029 Reset SHALL force state=IDLE, count=START_VALUE, prescaler=0, scan index=0, led=0, seg=7'h7F, an=all ones except an[0]=0, dp=1; reset asserted in any state, including mid-RUN, SHALL abort the round.

Configuration
REQ-030 With COUNTDOWN_SPLASH_EN defined, IDLE SHALL show "CL0." on digits 2,1,0 ('C'=7'b1000110, 'L'=7'b1000111, '0'=7'b1000000, dp=0 on digit 0) and blank the others; without it, IDLE SHALL blank all digits with dp=1 while scanning continues.

Structure
REQ-031 Package countdown_pkg SHALL hold the state enum, the glyph constants (blank, 'C', 'L', 'U', digits 0-9) and a function mapping a BCD digit to segments.
REQ-032 Sub-module digit_scanner SHALL own the SCAN_DIV divider, the scan index and the an/seg/dp registers; it SHALL be fed one glyph and one dp per digit.

Verification (CLOCK=20, SCAN_DIV=2, NDIGITS=4, START_VALUE=10)
REQ-033 sw=8'b1011_0001, multiply=0 -> led=4 after one cycle; multiply=1 -> led=8.
REQ-034 start pulse then wait 80 cycles -> count=6; digit 1 blank, digit 0 shows '6'.
REQ-035 led=6, stop asserted at count 6 -> WIN, digit 0=7'b1000001, count frozen for 200 cycles.
REQ-036 No stop -> LOSE exactly 200 cycles after start, digit 0=7'b1000111.
REQ-037 stop and tick in the same cycle at count 5, led=5 -> WIN.
REQ-038 reset mid-RUN -> IDLE on the next edge; with the macro, the "CL0." pattern appears with dp=0 on an[0]; without it, all digits are blank.
